// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: the control state
// encoding, common with the multiplier control unit.
package seq_divider_pkg;

    // Encoding 0 is never entered on purpose; it recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_ILLEGAL = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
//
// Handshake: the requester raises start with operands valid and holds it
// high until done is seen; operands are only sampled on the load edge
// (IDLE with start=1). done stays high, with results stable, for as long
// as start stays high; start must then be low for at least one edge before
// the next request is accepted.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int IN_WIDTH = 8
) ();

    logic                start;
    logic [IN_WIDTH-1:0] dividend;
    logic [IN_WIDTH-1:0] divisor;
    logic [IN_WIDTH-1:0] quotient;
    logic [IN_WIDTH-1:0] remainder;
    logic                done;
    logic                busy;
    logic                div_by_zero;
    state_t              state;       // debug view of the control state

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done, busy, div_by_zero, state
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done, busy, div_by_zero, state
    );

endinterface

// File: rtl/divider_control_unit.sv
// Control FSM of the sequential divider: sequences load, the per-bit
// iterations and the result write, and drives busy/done from the state.
module divider_control_unit
    import seq_divider_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_start,
    input  logic   i_div_zero,
    input  logic   i_last,
    output logic   o_load,
    output logic   o_en,
    output logic   o_write_result,
    output logic   o_busy,
    output logic   o_done,
    output state_t o_state
);

    state_t r_state;
    state_t w_next_state;

    // State register; reset lands in IDLE so busy/done drop immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_next_state   = r_state;
        o_load         = 1'b0;
        o_en           = 1'b0;
        o_write_result = 1'b0;
        o_busy         = 1'b0;
        o_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_div_zero) begin
                        // Zero divisor: write the saturated result now.
                        o_write_result = 1'b1;
                        w_next_state   = ST_DONE;
                    end else begin
                        o_load       = 1'b1;
                        w_next_state = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                o_en   = 1'b1;
                if (i_last) begin
                    o_write_result = 1'b1;
                    w_next_state   = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done = 1'b1;
                if (!i_start) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Holds the datapath (working registers, trial subtract, bit counter) and
// the registered results; sequencing lives in divider_control_unit.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int IN_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int CW = $clog2(IN_WIDTH + 1);

    // The partial remainder is always below the divisor, so its bit
    // IN_WIDTH is always zero after an iteration; only the low bits are kept.
    logic [IN_WIDTH-1:0] r_rem;
    logic [IN_WIDTH-1:0] r_quo;
    logic [IN_WIDTH-1:0] r_dvs;
    logic [CW-1:0]       r_count;
    logic [IN_WIDTH-1:0] r_quotient;
    logic [IN_WIDTH-1:0] r_remainder;
    logic                r_div_by_zero;

    logic                w_load;
    logic                w_en;
    logic                w_write_result;
    logic                w_div_zero;
    logic                w_last;
    logic [IN_WIDTH:0]   w_shift;
    logic [IN_WIDTH:0]   w_trial;
    logic [IN_WIDTH-1:0] w_rem_next;
    logic [IN_WIDTH-1:0] w_quo_next;

    assign w_div_zero = (bus.divisor == '0);
    assign w_last     = (r_count == CW'(1));

    // One restoring step: shift in the next dividend bit, try the subtract,
    // keep it only when it did not go negative.
    always_comb begin
        w_shift = {r_rem, r_quo[IN_WIDTH-1]};
        w_trial = w_shift - {1'b0, r_dvs};
        if (!w_trial[IN_WIDTH]) begin
            w_rem_next = w_trial[IN_WIDTH-1:0];
            w_quo_next = {r_quo[IN_WIDTH-2:0], 1'b1};
        end else begin
            w_rem_next = w_shift[IN_WIDTH-1:0];
            w_quo_next = {r_quo[IN_WIDTH-2:0], 1'b0};
        end
    end

    divider_control_unit u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .i_start        (bus.start),
        .i_div_zero     (w_div_zero),
        .i_last         (w_last),
        .o_load         (w_load),
        .o_en           (w_en),
        .o_write_result (w_write_result),
        .o_busy         (bus.busy),
        .o_done         (bus.done),
        .o_state        (bus.state)
    );

    // Working registers: capture operands on load, iterate while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_rem   <= '0;
            r_quo   <= bus.dividend;
            r_dvs   <= bus.divisor;
            r_count <= CW'(IN_WIDTH);
        end else if (w_en) begin
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_count <= r_count - CW'(1);
        end
    end

    // Result registers: written once per operation, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_write_result) begin
            if (w_en) begin
                r_quotient    <= w_quo_next;
                r_remainder   <= w_rem_next;
                r_div_by_zero <= 1'b0;
            end else begin
                r_quotient    <= '1;
                r_remainder   <= bus.dividend;
                r_div_by_zero <= 1'b1;
            end
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: an 8-bit and a 16-bit instance share one clock;
// results are compared against plain integer division.
module tb_seq_divider;
    import seq_divider_pkg::*;

    logic clk;
    logic rst;

    seq_divider_if #(.IN_WIDTH(8))  bus8 ();
    seq_divider_if #(.IN_WIDTH(16)) bus16 ();

    seq_divider #(.IN_WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    seq_divider #(.IN_WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive and monitor muxing: sel16 picks which instance is exercised
    logic        sel16;
    logic        drv_start;
    logic [15:0] drv_a;
    logic [15:0] drv_b;

    assign bus8.start     = drv_start & ~sel16;
    assign bus8.dividend  = drv_a[7:0];
    assign bus8.divisor   = drv_b[7:0];
    assign bus16.start    = drv_start & sel16;
    assign bus16.dividend = drv_a;
    assign bus16.divisor  = drv_b;

    logic [15:0] mon_q;
    logic [15:0] mon_r;
    logic        mon_done;
    logic        mon_busy;
    logic        mon_dbz;
    logic [1:0]  mon_state;

    assign mon_q     = sel16 ? bus16.quotient  : {8'h00, bus8.quotient};
    assign mon_r     = sel16 ? bus16.remainder : {8'h00, bus8.remainder};
    assign mon_done  = sel16 ? bus16.done        : bus8.done;
    assign mon_busy  = sel16 ? bus16.busy        : bus8.busy;
    assign mon_dbz   = sel16 ? bus16.div_by_zero : bus8.div_by_zero;
    assign mon_state = sel16 ? bus16.state       : bus8.state;

    // Scoreboard counters
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Driver: one full operation with reference-model checks.
    // perturb scrambles operands while the operation is in flight; hold keeps
    // start high for that many cycles after done.
    task automatic do_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                         input bit perturb, input int hold);
        int          w;
        logic [15:0] eq;
        logic [15:0] er;
        logic        edbz;
        int          elat;
        int          ebusy;
        int          lat;
        int          busyc;
        w = wide ? 16 : 8;
        if (b == 16'd0) begin
            eq    = wide ? 16'hFFFF : 16'h00FF;
            er    = a;
            edbz  = 1'b1;
            elat  = 1;
            ebusy = 0;
        end else begin
            eq    = a / b;
            er    = a % b;
            edbz  = 1'b0;
            elat  = w + 1;
            ebusy = w;
        end
        sel16     = wide;
        drv_a     = a;
        drv_b     = b;
        drv_start = 1'b1;
        lat       = 0;
        busyc     = 0;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (mon_busy) busyc++;
            if (mon_done) break;
            if (perturb) begin
                drv_a = 16'($urandom);
                drv_b = 16'($urandom);
            end
        end
        check("latency", lat, elat);
        check("busy_cycles", busyc, ebusy);
        check("quotient", 32'(mon_q), 32'(eq));
        check("remainder", 32'(mon_r), 32'(er));
        check("div_by_zero", 32'(mon_dbz), 32'(edbz));
        if (b != 16'd0) begin
            check("identity", 32'(mon_q) * 32'(b) + 32'(mon_r), 32'(a));
            check("rem_lt_div", 32'(mon_r < b), 32'd1);
        end
        for (int i = 0; i < hold; i++) begin
            drv_a = 16'($urandom);
            drv_b = 16'($urandom);
            @(negedge clk);
            check("hold_done", 32'(mon_done), 32'd1);
            check("hold_quotient", 32'(mon_q), 32'(eq));
            check("hold_remainder", 32'(mon_r), 32'(er));
        end
        drv_start = 1'b0;
        @(negedge clk);
        check("done_drop", 32'(mon_done), 32'd0);
        check("idle_state", 32'(mon_state), 32'(ST_IDLE));
        check("result_held", 32'(mon_q), 32'(eq));
    endtask

    logic [15:0] ra;
    logic [15:0] rb;

    initial begin
        sel16     = 1'b0;
        drv_start = 1'b0;
        drv_a     = '0;
        drv_b     = '0;
        rst       = 1'b1;
        @(negedge clk);
        check("reset_q", 32'(mon_q), 32'd0);
        check("reset_done", 32'(mon_done), 32'd0);
        check("reset_busy", 32'(mon_busy), 32'd0);
        check("reset_state", 32'(mon_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Directed 8-bit cases, including handshake hold and operand churn
        do_op(1'b0, 16'd100, 16'd7, 1'b1, 5);
        do_op(1'b0, 16'd255, 16'd1, 1'b0, 0);
        do_op(1'b0, 16'd5, 16'd200, 1'b0, 0);
        do_op(1'b0, 16'd200, 16'd200, 1'b0, 0);
        do_op(1'b0, 16'd0, 16'd9, 1'b0, 0);
        do_op(1'b0, 16'd42, 16'd0, 1'b0, 2);

        // Reset in the middle of RUN
        sel16     = 1'b0;
        drv_a     = 16'd200;
        drv_b     = 16'd3;
        drv_start = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_run_state", 32'(mon_state), 32'(ST_RUN));
        rst = 1'b1;
        #1;
        check("async_rst_q", 32'(mon_q), 32'd0);
        check("async_rst_r", 32'(mon_r), 32'd0);
        check("async_rst_dbz", 32'(mon_dbz), 32'd0);
        check("async_rst_busy", 32'(mon_busy), 32'd0);
        check("async_rst_done", 32'(mon_done), 32'd0);
        check("async_rst_state", 32'(mon_state), 32'(ST_IDLE));
        @(negedge clk);
        rst       = 1'b0;
        drv_start = 1'b0;
        @(negedge clk);
        do_op(1'b0, 16'd200, 16'd3, 1'b0, 0);

        // 16-bit instance
        do_op(1'b1, 16'd65535, 16'd255, 1'b0, 0);

        // Random 8-bit pairs, zero divisor now and then
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
            do_op(1'b0, ra, rb, 1'b0, 0);
        end

        // Random 16-bit pairs
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = ($urandom_range(0, 31) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            do_op(1'b1, ra, rb, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
